// File: rtl/multi_bit_f2s_arb.sv
// multi_bit_f2s_arb
//   Fast-domain (clka) round-robin arbiter that shares one multi-bit
//   fast-to-slow crossing channel between NUM_REQ requesters. A grant
//   launches {id, payload} with a 1-cycle valid pulse, then the channel is
//   held stable for HOLD_CYCLES clka cycles so the slow side can stretch,
//   synchronise and capture it.
//
// Ports
//   clka      fast clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        arbitration enable (no new grants while low)
//   req       per-requester request level
//   req_data  payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       one-hot 1-cycle pulse: word of that requester was launched
//   ch_data   {granted id, payload} to the crossing (held until next launch)
//   ch_valid  1-cycle launch pulse to the crossing
//   busy      high while the channel is held
//   xfer_cnt  launch count, 16-bit wrapping
module multi_bit_f2s_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ID_W        = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                          clka,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH+ID_W-1:0]    ch_data,
  output logic                          ch_valid,
  output logic                          busy,
  output logic [15:0]                   xfer_cnt
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [NUM_REQ-1:0]            ack_q, ack_d;
  logic [DATA_WIDTH+ID_W-1:0]    chd_q, chd_d;
  logic                          chv_q, chv_d;
  logic [15:0]                   xcnt_q, xcnt_d;

  logic [DATA_WIDTH-1:0]         words [NUM_REQ];
  logic                          found;
  logic [ID_W-1:0]               sel, cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // (a + b) mod NUM_REQ; keeps the pointer inside the legal id range even
  // when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                               input int b);
    int s;
    s = (int'(a) + b) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // First asserted request searching upward from the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    chv_d   = 1'b0;
    chd_d   = chd_q;
    xcnt_d  = xcnt_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          ptr_d   = wrap_add(sel, 1);
          ack_d   = NUM_REQ'(1) << sel;
          chv_d   = 1'b1;
          chd_d   = {sel, words[sel]};
          xcnt_d  = xcnt_q + 16'd1;
        end
      end
      HOLD: begin
        // req/en are ignored until the hold window has fully elapsed.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      chd_q   <= '0;
      chv_q   <= 1'b0;
      xcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      chd_q   <= chd_d;
      chv_q   <= chv_d;
      xcnt_q  <= xcnt_d;
    end
  end

  assign ack      = ack_q;
  assign ch_data  = chd_q;
  assign ch_valid = chv_q;
  assign busy     = (state_q == HOLD);
  assign xfer_cnt = xcnt_q;

endmodule

// File: tb/tb_multi_bit_f2s_arb.sv
// Self-checking bench for multi_bit_f2s_arb (NUM_REQ=4, DATA_WIDTH=8,
// ID_W=2, HOLD_CYCLES=4). Inputs change on the falling edge, outputs are
// checked on the falling edge against a cycle model and directed vectors.
module tb_multi_bit_f2s_arb;
  localparam int H = 4;

  logic        clka, rst_n, en;
  logic [3:0]  req;
  logic [7:0]  wd [4];
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [9:0]  ch_data;
  logic        ch_valid, busy;
  logic [15:0] xfer_cnt;

  int checks = 0, failures = 0;

  assign req_data = {wd[3], wd[2], wd[1], wd[0]};

  multi_bit_f2s_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_W(2), .HOLD_CYCLES(H)) dut (
    .clka(clka), .rst_n(rst_n), .en(en), .req(req), .req_data(req_data),
    .ack(ack), .ch_data(ch_data), .ch_valid(ch_valid), .busy(busy),
    .xfer_cnt(xfer_cnt)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reference model: remaining hold cycles, round-robin pointer, counter.
  int          m_hold;
  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;
  logic [3:0]  m_ack;
  logic        m_v;
  logic [9:0]  m_data;

  task automatic model_reset();
    m_hold = 0; m_ptr = 2'd0; m_cnt = 16'd0;
    m_ack = 4'd0; m_v = 1'b0; m_data = 10'd0;
  endtask

  task automatic model_edge();
    logic       fnd;
    logic [1:0] id;
    m_ack = 4'd0; m_v = 1'b0; fnd = 1'b0;
    if (m_hold > 0) m_hold--;
    else if (en && (req != 4'd0)) begin
      for (int k = 0; k < 4; k++) begin
        id = m_ptr + 2'(k);
        if (!fnd && req[id]) begin
          fnd    = 1'b1;
          m_ack  = 4'b0001 << id;
          m_v    = 1'b1;
          m_data = {id, wd[id]};
          m_cnt  = m_cnt + 16'd1;
          m_ptr  = id + 2'd1;
          m_hold = H;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ack",      32'(ack),      32'(m_ack));
    chk("ch_valid", 32'(ch_valid), 32'(m_v));
    chk("ch_data",  32'(ch_data),  32'(m_data));
    chk("busy",     32'(busy),     32'(m_hold > 0));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clka);
    model_edge();
    @(negedge clka);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clka);
    rst_n = 1'b0; req = 4'd0;
    model_reset();
    #1 check_all();
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        v;
    logic [9:0]  data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [13];
  int   gid [8];
  int   gcyc [8];
  logic [9:0] gdat [8];
  int   ng;

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 4'd0;
    wd[0] = 8'h77; wd[1] = 8'h3C; wd[2] = 8'hA5; wd[3] = 8'h00;
    model_reset();
    #1 check_all();
    @(negedge clka);
    check_all();
    rst_n = 1'b1;

    // Single request, hold length, then en gating with a pending request.
    tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 10'h2A5, 1'b1, 16'd1};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 10'h2A5, 1'b1, 16'd1};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 10'h2A5, 1'b1, 16'd1};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 10'h2A5, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 10'h2A5, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 10'h077, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 10'h077, 1'b1, 16'd2};
    tbl[7]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 10'h077, 1'b1, 16'd2};
    tbl[8]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 10'h077, 1'b1, 16'd2};
    tbl[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 10'h077, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 10'h077, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 10'h13C, 1'b1, 16'd3};
    tbl[12] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 10'h13C, 1'b1, 16'd3};
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; req = tbl[i].req;
      step();
      chk($sformatf("vec%0d.ack", i),   32'(ack),      32'(tbl[i].ack));
      chk($sformatf("vec%0d.valid", i), 32'(ch_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d.data", i),  32'(ch_data),  32'(tbl[i].data));
      chk($sformatf("vec%0d.busy", i),  32'(busy),     32'(tbl[i].busy));
      chk($sformatf("vec%0d.cnt", i),   32'(xfer_cnt), 32'(tbl[i].cnt));
    end
    req = 4'd0;

    // All requesters at once; each drops req the cycle after its ack.
    do_reset();
    wd[0] = 8'h10; wd[1] = 8'h11; wd[2] = 8'h12; wd[3] = 8'h13;
    en = 1'b1; req = 4'b1111; ng = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ch_valid && ng < 8) begin
        gid[ng] = int'(ch_data[9:8]); gdat[ng] = ch_data; gcyc[ng] = c; ng++;
      end
      req = req & ~ack;
    end
    chk("all.grants", 32'(ng), 32'd4);
    for (int g = 0; g < 4 && g < ng; g++) begin
      chk($sformatf("all.id%0d", g),   32'(gid[g]),  32'(g));
      chk($sformatf("all.data%0d", g), 32'(gdat[g]), 32'({2'(g), 8'h10 + 8'(g)}));
      if (g > 0) chk($sformatf("all.gap%0d", g), 32'(gcyc[g] - gcyc[g-1]), 32'(H + 1));
    end

    // Fairness: req0 and req3 both held; grants must alternate.
    do_reset();
    req = 4'b1001; ng = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (ch_valid && ng < 8) begin gid[ng] = int'(ch_data[9:8]); ng++; end
    end
    chk("fair.grants", 32'(ng >= 4), 32'd1);
    for (int g = 0; g < 4 && g < ng; g++)
      chk($sformatf("fair.id%0d", g), 32'(gid[g]), (g % 2 == 0) ? 32'd0 : 32'd3);
    req = 4'd0;

    // Reset two cycles into HOLD aborts everything at once.
    repeat (H + 1) step();
    req = 4'b0001; step();
    req = 4'b0000; step(); step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ch_data", 32'(ch_data), 32'd0);
    chk("rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
    check_all();
    @(negedge clka);
    rst_n = 1'b1; req = 4'b1000;
    step();
    chk("rst.first_ack", 32'(ack), 32'b1000);
    chk("rst.first_data", 32'(ch_data), 32'({2'd3, wd[3]}));
    req = 4'd0;

    // Counter wrap: preload 0xFFFF while idle, next launch shows 0.
    repeat (H + 1) step();
    force dut.xcnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.xcnt_q;
    req = 4'b0100;
    step();
    chk("wrap.cnt", 32'(xfer_cnt), 32'd0);
    chk("wrap.valid", 32'(ch_valid), 32'd1);
    req = 4'd0;

    // Randomized traffic obeying the handshake, with withdrawals and en noise.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[2'(i)] && ack[2'(i)])                  req[2'(i)] = 1'b0;
        else if (req[2'(i)] && $urandom_range(0, 29) == 0) req[2'(i)] = 1'b0;
        else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
          req[2'(i)] = 1'b1;
          wd[2'(i)]  = 8'($urandom);
        end
      end
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_bit_f2s_arb.md
Name: multi_bit_f2s_arb

Overview:
- Fast-domain (clka) arbiter and sequencer that shares one multi-bit fast-to-slow crossing channel between NUM_REQ requesters.
- Picks one requester round-robin, launches its word with a 1-cycle valid pulse, then holds the channel stable for HOLD_CYCLES clka cycles so the slow side can stretch, sync and capture it.
- Sits directly upstream of the multi-bit f2s synchroniser; ch_data/ch_valid drive its din/valid_in.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, payload width per requester.
- ID_W, 2, requester-index width; must satisfy 2**ID_W >= NUM_REQ.
- HOLD_CYCLES, 8, clka cycles the channel stays busy after a launch (>=1). Integrator sets it to at least 3 clkb periods plus 1 clka period, expressed in clka cycles.

Ports:
- clka, in, 1, fast clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, arbitration enable; when low, no new grants.
- req, in, NUM_REQ, per-requester request level.
- req_data, in, NUM_REQ*DATA_WIDTH, payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack, out, NUM_REQ, one-hot 1-cycle pulse meaning the word was launched.
- ch_data, out, DATA_WIDTH+ID_W, {granted id, payload} to the crossing.
- ch_valid, out, 1, 1-cycle launch pulse to the crossing.
- busy, out, 1, high while in HOLD.
- xfer_cnt, out, 16, count of launches; wraps 0xFFFF to 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack=0, ch_data=0, ch_valid=0, busy=0, xfer_cnt=0; round-robin pointer=0. Reset asserted mid-HOLD aborts the transfer immediately with no ack, no pulse and no count.
- States: IDLE and HOLD.
- IDLE:
  - If en=1 and |req=1, select the first asserted req searching upward from the pointer with wrap-around.
  - At that clock edge: ch_data <= {idx, word idx}; ch_valid <= 1; ack[idx] <= 1; xfer_cnt += 1; pointer <= (idx+1) mod NUM_REQ; cnt <= HOLD_CYCLES-1; state <= HOLD.
  - Launch latency: req sampled in cycle t gives ch_valid and ack high in cycle t+1.
- HOLD:
  - busy=1; ch_valid=0 and ack=0 after the launch cycle. The launch cycle itself shows ch_valid=ack=busy=1.
  - cnt decrements each cycle; at cnt==0 state <= IDLE.
  - req and en are ignored.
- Channel rate: minimum launch-to-launch spacing is HOLD_CYCLES+1 clka cycles.
- ch_data holds its value until the next launch and is never cleared except by reset.
- Handshake:
  - Requester holds req and its word stable until it sees ack.
  - Requester deasserts req the cycle after ack.
  - A req still high when the block returns to IDLE counts as a new request.
  - Dropping req before ack withdraws the request with no side effect.
- Simultaneous requests: strict round-robin from the pointer. Pointer advances only on a grant.
- en=0 during HOLD: the current hold completes normally, then the block stays in IDLE. Re-asserting en allows a grant the same cycle.
- NUM_REQ not a power of two: pointer wraps at NUM_REQ; unused id codes never appear.
- xfer_cnt: 16-bit modular increment, one per ch_valid pulse.

Test Plan:
- Bench config: NUM_REQ=4, DATA_WIDTH=8, ID_W=2, HOLD_CYCLES=4.
- Single request: after reset, req=4'b0100 with word2=8'hA5. Next cycle: ch_valid=1, ack=4'b0100, ch_data=10'h2A5. busy high 4 cycles; xfer_cnt=1.
- All requesters: req=4'b1111 with words 8'h10, 8'h11, 8'h12, 8'h13; each drops req after its ack. Grants go 0,1,2,3 with ch_valid pulses exactly 5 cycles apart; ch_data sequence is 10'h010, 10'h111, 10'h212, 10'h313.
- Fairness: req0 held permanently (re-requests after every ack), req3 asserted. Grants alternate 0,3,0,3; req3 is never starved.
- en gating: en dropped during HOLD with req=4'b0010 pending. The hold ends and no pulse follows. Raising en gives a launch of id 1 the next cycle.
- Reset mid-transfer: assert rst_n=0 two cycles into HOLD. All outputs are 0 immediately. After release, req=4'b1000 is granted; pointer starts at 0, so id 3 is the first grant.
- Counter wrap: preload via 65535 launches, or force the register. The next launch shows xfer_cnt=0.
